// File: rtl/async_fifo_rd_stream.sv
// Read-domain drain stage: credit-based FIFO read issue, small prefetch buffer, valid/ready output.
// Define ASYNC_FIFO_RD_STREAM_CNT_EN to build the delivered-beat counter on o_beat_cnt.
module async_fifo_rd_stream #(
    parameter int DW = 8,
    parameter int BW = 1
) (
    input  logic          rd_clk,
    input  logic          rd_sw_rst,
    output logic          o_fifo_rd_en,
    input  logic [DW-1:0] i_fifo_rd_data,
    input  logic          i_fifo_rd_valid,
    input  logic          i_fifo_empty,
    output logic [DW-1:0] o_m_data,
    output logic          o_m_valid,
    input  logic          i_m_ready,
    output logic [BW:0]   o_level,
    output logic          o_ovf_err,
    output logic [15:0]   o_beat_cnt
);

    localparam int            DEPTH   = 1 << BW;
    localparam logic [BW:0]   DEPTH_C = (BW+1)'(DEPTH);
    localparam logic [BW+1:0] DEPTH_X = (BW+2)'(DEPTH);

    logic [DW-1:0] buf_mem [DEPTH];
    logic [BW-1:0] wr_ptr;
    logic [BW-1:0] rd_ptr;
    logic [BW:0]   count;
    logic          inflight;
    logic          ovf;
    logic          pop;
    logic          push;
    logic [BW+1:0] committed;

    assign o_m_valid = (count != '0);
    assign o_m_data  = buf_mem[rd_ptr];
    assign pop       = o_m_valid & i_m_ready;
    assign o_level   = count;
    assign o_ovf_err = ovf;

    // Slots already owed to the buffer: stored beats plus the outstanding request, less this cycle's pop.
    assign committed    = {1'b0, count} + {{(BW+1){1'b0}}, inflight} - {{(BW+1){1'b0}}, pop};
    assign o_fifo_rd_en = ~rd_sw_rst & ~i_fifo_empty & (committed < DEPTH_X);

    assign push = i_fifo_rd_valid & ((count < DEPTH_C) | pop);

    always_ff @(posedge rd_clk) begin
        if (rd_sw_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            inflight <= o_fifo_rd_en;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_fifo_rd_valid & ~push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push) buf_mem[wr_ptr] <= i_fifo_rd_data;
    end

`ifdef ASYNC_FIFO_RD_STREAM_CNT_EN
    logic [15:0] beat_cnt;

    always_ff @(posedge rd_clk) begin
        if (rd_sw_rst)  beat_cnt <= '0;
        else if (pop)   beat_cnt <= beat_cnt + 16'd1;
    end

    assign o_beat_cnt = beat_cnt;
`else
    assign o_beat_cnt = '0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: vector table, hand-written corner sequences, and a
// randomized run against a FIFO/scoreboard model that answers each read one cycle later.
module tb_async_fifo_rd_stream;

    localparam int DW    = 8;
    localparam int BW    = 1;
    localparam int DEPTH = 1 << BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_vld = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [BW:0]   level;
    logic          ovf_err;
    logic [15:0]   beat_cnt;

    async_fifo_rd_stream #(.DW(DW), .BW(BW)) dut (
        .rd_clk          (clk),
        .rd_sw_rst       (rst),
        .o_fifo_rd_en    (fifo_rd_en),
        .i_fifo_rd_data  (fifo_data),
        .i_fifo_rd_valid (fifo_vld),
        .i_fifo_empty    (fifo_empty),
        .o_m_data        (m_data),
        .o_m_valid       (m_valid),
        .i_m_ready       (m_ready),
        .o_level         (level),
        .o_ovf_err       (ovf_err),
        .o_beat_cnt      (beat_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: beats the DUT accepted minus beats it delivered, and what it must deliver next.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int lvl, npop, cyc, first_pop, last_pop, mode;
    bit starve;

    typedef struct {
        bit            rst, empty, vld;
        logic [DW-1:0] data;
        bit            rdy;
        bit            e_rd_en, e_mv;
        logic [DW-1:0] e_md;
        int            e_lvl;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; fifo_vld = 1'b0; fifo_empty = 1'b1; m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        src_q.delete(); exp_q.delete();
        lvl = 0; npop = 0; cyc = 0; first_pop = -1; last_pop = -1;
    endtask

    task automatic drv(input bit r, input bit e, input bit v, input logic [DW-1:0] d, input bit rd);
        @(posedge clk); #1;
        rst = r; fifo_empty = e; fifo_vld = v; fifo_data = d; m_ready = rd;
        @(negedge clk);
    endtask

    // One cycle of the modelled FIFO + consumer; checks the DUT against the model.
    task automatic cycle();
        bit req, p;
        logic [DW-1:0] d;
        @(negedge clk);
        req = fifo_rd_en;
        p   = m_valid && m_ready;
        chk("level", level, lvl);
        chk("m_valid", m_valid, lvl != 0);
        chk("ovf", ovf_err, 0);
        if (lvl == DEPTH && !p) chk("rd_en_full", fifo_rd_en, 0);
        if (p) begin
            if (exp_q.size() > 0) begin
                d = exp_q.pop_front();
                chk("data", m_data, d);
            end
            npop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk);
        lvl = lvl + int'(fifo_vld) - int'(p);
        if (fifo_vld) exp_q.push_back(fifo_data);
        #1;
        if (req && src_q.size() > 0) begin
            fifo_vld  = 1'b1;
            fifo_data = src_q.pop_front();
        end else begin
            fifo_vld = 1'b0;
        end
        fifo_empty = (src_q.size() == 0) || (starve && $urandom_range(3) == 0);
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = $urandom_range(1) == 1;
        endcase
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   exp_cnt;

        vt[0] = '{1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0};
        vt[1] = '{0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0};
        vt[2] = '{0, 0, 1, 8'h11, 1, 1, 0, 8'h00, 0};
        vt[3] = '{0, 0, 1, 8'h22, 1, 1, 1, 8'h11, 1};
        vt[4] = '{0, 1, 1, 8'h33, 1, 0, 1, 8'h22, 1};
        vt[5] = '{0, 1, 0, 8'h00, 1, 0, 1, 8'h33, 1};
        vt[6] = '{0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 0};

        // First-word latency and back-to-back delivery of a three-entry FIFO.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drv(vt[i].rst, vt[i].empty, vt[i].vld, vt[i].data, vt[i].rdy);
            chk($sformatf("vec%0d_rd_en", i), fifo_rd_en, vt[i].e_rd_en);
            chk($sformatf("vec%0d_m_valid", i), m_valid, vt[i].e_mv);
            chk($sformatf("vec%0d_level", i), level, vt[i].e_lvl);
            if (vt[i].e_mv) chk($sformatf("vec%0d_m_data", i), m_data, vt[i].e_md);
        end

        // 100 beats, ready always high: no bubbles once started.
        do_reset();
        starve = 0; mode = 0;
        for (int i = 0; i < 100; i++) src_q.push_back(DW'(i + 1));
        for (int i = 0; i < 400 && npop < 100; i++) cycle();
        chk("stream_pops", npop, 100);
        chk("stream_no_bubble", last_pop - first_pop, 99);
        @(negedge clk);
`ifdef ASYNC_FIFO_RD_STREAM_CNT_EN
        exp_cnt = 100;
`else
        exp_cnt = 0;
`endif
        chk("stream_beat_cnt", beat_cnt, exp_cnt);

        // Ready held low for 20 cycles: buffer fills, requests stop, nothing lost.
        do_reset();
        starve = 0; mode = 1;
        for (int i = 0; i < 10; i++) src_q.push_back(DW'(8'hA0 + i));
        for (int i = 0; i < 20; i++) cycle();
        @(negedge clk);
        chk("stall_level", level, DEPTH);
        chk("stall_rd_en", fifo_rd_en, 0);
        mode = 0;
        for (int i = 0; i < 100 && npop < 10; i++) cycle();
        chk("stall_pops", npop, 10);
        chk("stall_src_drained", src_q.size(), 0);

        // Random backpressure and FIFO starvation over 1000 beats.
        do_reset();
        starve = 1; mode = 2;
        for (int i = 0; i < 1000; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 8000 && npop < 1000; i++) cycle();
        chk("rand_pops", npop, 1000);
        @(negedge clk);
`ifdef ASYNC_FIFO_RD_STREAM_CNT_EN
        exp_cnt = 1000;
`else
        exp_cnt = 0;
`endif
        chk("rand_beat_cnt", beat_cnt, exp_cnt);

        // Overflow: third beat into a full, stalled buffer is dropped and the error is sticky.
        do_reset();
        drv(0, 1, 1, 8'hA1, 0); chk("ovf_lvl0", level, 0);
        drv(0, 1, 1, 8'hB2, 0); chk("ovf_lvl1", level, 1);
        drv(0, 1, 1, 8'hC3, 0); chk("ovf_lvl2", level, 2); chk("ovf_pre", ovf_err, 0);
        drv(0, 1, 0, 8'h00, 0); chk("ovf_set", ovf_err, 1); chk("ovf_full", level, 2);
        drv(0, 1, 0, 8'h00, 1); chk("ovf_d0", m_data, 8'hA1); chk("ovf_hold1", ovf_err, 1);
        drv(0, 1, 0, 8'h00, 1); chk("ovf_d1", m_data, 8'hB2); chk("ovf_lvl_d1", level, 1);
        drv(0, 1, 0, 8'h00, 1); chk("ovf_empty", m_valid, 0); chk("ovf_hold2", ovf_err, 1);
        drv(1, 1, 0, 8'h00, 0); chk("ovf_hold_rst", ovf_err, 1);
        drv(0, 1, 0, 8'h00, 0); chk("ovf_cleared", ovf_err, 0);

        // Reset mid-stream with a request outstanding; its late beat is the first one out.
        do_reset();
        drv(0, 0, 0, 8'h00, 0); chk("ri_rd_en0", fifo_rd_en, 1);
        drv(0, 0, 1, 8'h77, 0); chk("ri_rd_en1", fifo_rd_en, 1); chk("ri_lvl0", level, 0);
        drv(1, 0, 0, 8'h00, 0); chk("ri_rst_rd_en", fifo_rd_en, 0); chk("ri_lvl1", level, 1);
        drv(0, 1, 1, 8'h5A, 0); chk("ri_lvl_rst", level, 0); chk("ri_mv_rst", m_valid, 0);
        drv(0, 1, 0, 8'h00, 1); chk("ri_lvl_new", level, 1); chk("ri_mv_new", m_valid, 1);
        chk("ri_data", m_data, 8'h5A);
        drv(0, 1, 0, 8'h00, 1); chk("ri_drained", level, 0); chk("ri_ovf", ovf_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
